// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder
package dmem_pkg;
    localparam logic [7:0] OFF_LED   = 8'h00;
    localparam logic [7:0] OFF_SW    = 8'h04;
    localparam logic [7:0] OFF_CYCLE = 8'h08;
    localparam logic [7:0] OFF_TCMP  = 8'h0C;
    localparam logic [7:0] OFF_TCTRL = 8'h10;
    localparam logic [7:0] OFF_TCNT  = 8'h14;
    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_FLAG   = 1;
    localparam int TCTRL_RELOAD = 2;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: compare timer with one-shot/reload modes and sticky flag
module dmem_timer import dmem_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_tcmp,
    input  logic        we_tctrl,
    input  logic        we_tcnt,
    input  logic [31:0] wdata,
    output logic [31:0] tcmp,
    output logic [31:0] tctrl,
    output logic [31:0] tcnt,
    output logic        irq
);
    logic en, reload, flag, match;
    assign match = en && tcnt == tcmp;
    assign tctrl = {29'b0, reload, flag, en};
    assign irq = flag;
    always_ff @(posedge clk)
        if (rst) begin
            tcmp   <= '1;
            tcnt   <= '0;
            en     <= 1'b0;
            reload <= 1'b0;
            flag   <= 1'b0;
        end else begin
            tcmp   <= we_tcmp ? wdata : tcmp;
            reload <= we_tctrl ? wdata[TCTRL_RELOAD] : reload;
            en     <= we_tctrl ? wdata[TCTRL_EN] : (match && !reload) ? 1'b0 : en;
            flag   <= match ? 1'b1 : (we_tctrl && wdata[TCTRL_FLAG]) ? 1'b0 : flag;
            tcnt   <= we_tcnt ? wdata : !en ? tcnt : !match ? tcnt + 32'd1 : reload ? '0 : tcnt;
        end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with byte-lane RAM and MMIO block
module dmem_responder import dmem_pkg::*; #(
    parameter int          AW        = 10,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        timer_irq
);
    logic [31:0] mem [2**AW];
    logic [31:0] cycle, wword, mmio_rd, tcmp, tctrl, tcnt;
    logic [15:0] sw_s1, sw_s2;
    logic [7:0]  off;
    logic        ram_sel, mmio_sel, lane_ok, mmio_we;
    assign ram_sel  = addr[31:AW+2] == '0;
    assign mmio_sel = addr[31:8] == MMIO_BASE[31:8];
    assign off      = addr[7:0] & 8'hFC;
    assign lane_ok  = be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    assign wword    = be == 4'hF ? writedata : (be == 4'h3 || be == 4'hC) ? {2{writedata[15:0]}} : {4{writedata[7:0]}};
    assign mmio_we  = MemWrite && mmio_sel && be == 4'hF;
    always_ff @(posedge clk)
        if (!rst && MemWrite && ram_sel && lane_ok)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
    always_ff @(posedge clk)
        if (rst) begin
            led_o <= '0;
            cycle <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            led_o <= (mmio_we && off == OFF_LED) ? writedata[15:0] : led_o;
            cycle <= (mmio_we && off == OFF_CYCLE) ? writedata : cycle + 32'd1;
            sw_s1 <= sw_i;
            sw_s2 <= sw_s1;
        end
    dmem_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .we_tcmp  (mmio_we && off == OFF_TCMP),
        .we_tctrl (mmio_we && off == OFF_TCTRL),
        .we_tcnt  (mmio_we && off == OFF_TCNT),
        .wdata    (writedata),
        .tcmp     (tcmp),
        .tctrl    (tctrl),
        .tcnt     (tcnt),
        .irq      (timer_irq)
    );
    always_comb begin
        mmio_rd = '0;
        case (off)
            OFF_LED:   mmio_rd = {16'b0, led_o};
            OFF_SW:    mmio_rd = {16'b0, sw_s2};
            OFF_CYCLE: mmio_rd = cycle;
            OFF_TCMP:  mmio_rd = tcmp;
            OFF_TCTRL: mmio_rd = tctrl;
            OFF_TCNT:  mmio_rd = tcnt;
            default:   mmio_rd = '0;
        endcase
    end
    assign rdata = ram_sel ? mem[addr[AW+1:2]] : mmio_sel ? mmio_rd : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder
module tb_dmem_responder;
    localparam logic [31:0] A_LED = 32'hFFFF_0000, A_SW = 32'hFFFF_0004, A_CYC = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP = 32'hFFFF_000C, A_TCTRL = 32'hFFFF_0010, A_TCNT = 32'hFFFF_0014;
    logic        clk = 0, rst = 1, MemWrite = 0, timer_irq;
    logic [31:0] addr = 0, writedata = 0, rdata;
    logic [3:0]  be = 0;
    logic [15:0] sw_i = 0, led_o;
    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    dmem_responder dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .addr(addr), .be(be),
        .writedata(writedata), .rdata(rdata), .sw_i(sw_i), .led_o(led_o), .timer_irq(timer_irq)
    );

    always #50 clk = ~clk;

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        MemWrite = 1; addr = a; be = b; writedata = d;
        tick();
        MemWrite = 0; be = 0;
    endtask

    task automatic rexp(input string t, input logic [31:0] a, input logic [31:0] v);
        push(t, v);
        addr = a;
        #1;
        check(rdata);
    endtask

    task automatic irq_exp(input string t, input logic v);
        push(t, {31'b0, v});
        check({31'b0, timer_irq});
    endtask

    initial begin
        tick();
        rst = 0;
        // CYCLE counts from reset, then wraps after a load
        push("cyc0", 0); push("cyc1", 1); push("cyc2", 2);
        addr = A_CYC; #1;
        check(rdata); tick(); check(rdata); tick(); check(rdata);
        wr(A_CYC, 4'hF, 32'hFFFF_FFFE);
        push("cyc_w0", 32'hFFFF_FFFE); push("cyc_w1", 32'hFFFF_FFFF); push("cyc_wrap", 0);
        check(rdata); tick(); check(rdata); tick(); check(rdata);
        // RAM lanes
        wr(32'h10, 4'hF, 32'h1122_3344);
        wr(32'h12, 4'b0100, 32'h0000_00AB);
        rexp("byte_lane2", 32'h10, 32'h11AB_3344);
        wr(32'h10, 4'b1100, 32'h0000_BEEF);
        rexp("half_hi", 32'h10, 32'hBEEF_3344);
        wr(32'h10, 4'b0110, 32'hFFFF_FFFF);
        rexp("bad_be", 32'h10, 32'hBEEF_3344);
        wr(32'h10, 4'b0000, 32'hFFFF_FFFF);
        rexp("zero_be", 32'h10, 32'hBEEF_3344);
        wr(32'h14, 4'hF, 32'h0);
        wr(32'h14, 4'b0011, 32'h1234_CAFE);
        rexp("half_lo", 32'h14, 32'h0000_CAFE);
        wr(32'h17, 4'b1000, 32'h0000_0077);
        rexp("byte_lane3", 32'h14, 32'h7700_CAFE);
        rexp("unmapped", 32'h8000_0000, 0);
        wr(32'h0, 4'hF, 32'h5555_5555);
        wr(32'hFFC, 4'hF, 32'hA0A0_0F0F);
        wr(32'h1000, 4'hF, 32'hDEAD_BEEF);
        rexp("ram_top", 32'hFFC, 32'hA0A0_0F0F);
        rexp("ram_end_rd", 32'h1000, 0);
        rexp("no_alias", 32'h0, 32'h5555_5555);
        // LED / SW
        wr(A_LED, 4'hF, 32'h0000_A5A5);
        push("led_o", 32'hA5A5); check({16'b0, led_o});
        rexp("led_rd", A_LED, 32'h0000_A5A5);
        wr(A_LED, 4'b0001, 32'hFFFF_FFFF);
        push("led_partial", 32'hA5A5); check({16'b0, led_o});
        rexp("bad_off", 32'hFFFF_0018, 0);
        sw_i = 16'h00F0;
        rexp("sw_lat0", A_SW, 0);
        push("sw_lat1", 0); push("sw_lat2", 32'h0000_00F0);
        tick(); check(rdata); tick(); check(rdata);
        // timer one-shot
        rexp("tcmp_rst", A_TCMP, 32'hFFFF_FFFF);
        wr(A_TCMP, 4'hF, 3);
        wr(A_TCTRL, 4'hF, 1);
        push("tcnt0", 0); push("tcnt1", 1); push("tcnt2", 2); push("tcnt3", 3);
        addr = A_TCNT; #1;
        check(rdata); tick(); check(rdata); tick(); check(rdata); tick(); check(rdata);
        irq_exp("irq_before", 0);
        tick();
        irq_exp("irq_oneshot", 1);
        rexp("tctrl_oneshot", A_TCTRL, 32'h2);
        rexp("tcnt_hold", A_TCNT, 3);
        tick();
        rexp("tcnt_hold2", A_TCNT, 3);
        wr(A_TCTRL, 4'hF, 2);
        irq_exp("irq_w1c", 0);
        // reload mode
        wr(A_TCNT, 4'hF, 0);
        wr(A_TCTRL, 4'hF, 5);
        tick(); tick(); tick();
        irq_exp("irq_pre_reload", 0);
        tick();
        irq_exp("irq_reload1", 1);
        rexp("tcnt_reloaded", A_TCNT, 0);
        wr(A_TCTRL, 4'hF, 7);
        irq_exp("irq_clr", 0);
        tick(); tick();
        irq_exp("irq_mid", 0);
        tick();
        irq_exp("irq_reload2", 1);
        // W1C in the match cycle: set wins
        wr(A_TCTRL, 4'hF, 7);
        irq_exp("irq_clr2", 0);
        tick(); tick();
        wr(A_TCTRL, 4'hF, 7);
        irq_exp("irq_set_wins", 1);
        rexp("tctrl_set_wins", A_TCTRL, 32'h7);
        rexp("tcnt_after_w1c", A_TCNT, 0);
        // reset drops concurrent writes
        wr(32'h20, 4'hF, 32'hCAFE_F00D);
        rst = 1; MemWrite = 1; addr = A_LED; be = 4'hF; writedata = 32'h0000_1234;
        tick();
        addr = 32'h20; writedata = 0;
        tick();
        rst = 0; MemWrite = 0; be = 0;
        push("led_rst", 0); check({16'b0, led_o});
        irq_exp("irq_rst", 0);
        rexp("tcnt_rst", A_TCNT, 0);
        rexp("tctrl_rst", A_TCTRL, 0);
        rexp("cyc_rst", A_CYC, 0);
        rexp("ram_rst_drop", 32'h20, 32'hCAFE_F00D);
        rexp("sw_rst", A_SW, 0);
        tick();
        rexp("tcnt_idle", A_TCNT, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle core: the slave end of the core's data-memory interface (address = ALU result, store data, byte enables, write strobe, read word back). It holds a byte-lane-writable data RAM and a small memory-mapped I/O block: LED, switch, cycle counter and compare timer. Reads are combinational so the core completes loads in its single cycle. Writes commit on the clock edge.

## Interface
- `AW`, default 10: RAM word-address width; RAM holds 2^AW 32-bit words.
- `MMIO_BASE`, default 32'hFFFF_0000: base of the I/O region.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `MemWrite`, in, 1: store strobe from the core.
- `addr`, in, 32: byte address (the core's aluout).
- `be`, in, 4: byte enables; bit i = byte lane i (bits 8i+7:8i).
- `writedata`, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`, out, 32: whole addressed word, unextended. The core does sub-word extraction.
- `sw_i`, in, 16: board switches, asynchronous.
- `led_o`, out, 16: LED register.
- `timer_irq`, out, 1: timer flag level.

## Operation
- Decode:
  - RAM when addr < 4·2^AW.
  - MMIO when addr[31:8] == MMIO_BASE[31:8].
  - Otherwise unmapped: rdata = 0, writes ignored.
  - addr[1:0] ignored for decode.
- RAM write lane alignment:
  - be one-hot at lane k: lane k ← writedata[7:0].
  - be 4'b0011 or 4'b1100: those lanes ← writedata[15:0].
  - be 4'hF: full word.
  - Any other be pattern (including 0): no write.
  - RAM contents are not reset.
- MMIO writes are honored only when be == 4'hF; partial MMIO writes are ignored.
- MMIO registers, byte offset: meaning, reset value:
  - 0x00 LED: RW; bits [15:0] drive led_o; reads zero-extended; reset 0.
  - 0x04 SW: RO; sw_i through a 2-flop synchronizer, zero-extended; sync flops reset 0.
  - 0x08 CYCLE: +1 every cycle, wraps FFFF_FFFF→0. A write loads writedata, and the write wins over the increment. Reset 0.
  - 0x0C TCMP: RW; reset FFFF_FFFF.
  - 0x10 TCTRL bits:
    - bit0 EN: RW.
    - bit1 FLAG: reads the flag; writing 1 clears it, writing 0 has no effect.
    - bit2 RELOAD: RW.
    - Other bits read 0.
    - Reset 0.
  - 0x14 TCNT: RW; reset 0.
  - Other offsets: read 0, write ignored.
- Timer, evaluated each cycle when EN = 1:
  - If TCNT == TCMP: FLAG ← 1. If RELOAD = 1, TCNT ← 0; else TCNT holds and EN ← 0.
  - Otherwise TCNT ← TCNT + 1.
  - EN = 0: TCNT holds.
- Simultaneous timer events:
  - Software write to TCNT wins over count/reload.
  - Write to TCTRL sets EN/RELOAD; a match in the same cycle still sets FLAG.
  - FLAG set and W1C in the same cycle: set wins.
- timer_irq = FLAG.

## Timing
- rdata is combinational from addr and current state, valid in the same cycle. There is no read side effect.
- A store is visible to a read in the cycle after its edge. A read of CYCLE returns the pre-edge value.
- Write to TCMP/TCNT takes effect at the edge. The match compare uses the register values before that edge.
- SW read latency: 2 cycles from sw_i change.
- Reset:
  - rst high at an edge: every MMIO register, the synchronizer and timer state take their reset values.
  - Any MemWrite in that cycle is dropped, including RAM writes.
  - Outputs after reset: led_o = 0, timer_irq = 0. rdata reflects the reset state; RAM content is undefined.
- Reset mid-count: TCNT, EN and FLAG clear; counting resumes only after software sets EN.

## Structure
- Package `dmem_pkg`:
  - MMIO offset constants (LED, SW, CYCLE, TCMP, TCTRL, TCNT).
  - TCTRL bit indices (EN = 0, FLAG = 1, RELOAD = 2).
  - Default MMIO_BASE.
- Sub-module `dmem_timer`: TCMP/TCTRL/TCNT registers, match/reload logic and FLAG. It takes decoded write strobes and writedata and returns read values and irq.
- RAM array, lane alignment, CYCLE, LED, synchronizer and read mux live in the top.

## Test plan
- Byte store: write 32'h1122_3344 to 0x10 with be = F; then MemWrite at 0x12, be = 4'b0100, writedata = 32'h0000_00AB → read 0x10 = 32'h11AB_3344.
- Half store and invalid be: be = 4'b1100, writedata = 32'h0000_BEEF at 0x10 → 32'hBEEF_3344. Then be = 4'b0110 → word unchanged. Unmapped 0x8000_0000 reads 0.
- LED/SW:
  - Full write 32'h0000_A5A5 to 0xFFFF_0000 → led_o = A5A5 next cycle.
  - be = 4'b0001 write → led_o unchanged.
  - sw_i = 16'h00F0 → SW reads 32'h0000_00F0 two cycles later.
- CYCLE:
  - After reset, reads 0, 1, 2 on consecutive cycles.
  - Write FFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, 0.
- Timer one-shot then reload:
  - TCMP = 3, TCTRL = 1 → TCNT 0,1,2,3; timer_irq rises the cycle after TCNT reads 3; EN reads 0; TCNT holds 3.
  - Write TCTRL = 2 → irq clears.
  - TCTRL = 5 with TCNT = 0 → irq every 4 cycles.
- Contention and reset:
  - W1C to FLAG in the match cycle → FLAG stays 1.
  - Assert rst with MemWrite = 1 to LED → led_o = 0, write dropped, TCNT/TCTRL = 0, CYCLE = 0.
